// File: rtl/ej32_pkg.sv
// Shared types and defaults for the ej32 memory arbiter.
// Covers the arbiter FSM states, the statistics bundle and a saturating helper.
package ej32_pkg;

    localparam int ASZ_DEF    = 17;
    localparam int LSZ_DEF    = 9;
    localparam int STARVE_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } arb_state_t;

    typedef struct packed {
        logic [15:0] core;
        logic [15:0] host;
        logic [15:0] stall;
    } arb_stat_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ej32_arb_starve.sv
// Host starvation counter: counts core-won cycles while the host waits.
// Saturates at STARVE_MAX and raises starved_o to force a host slot.
module ej32_arb_starve #(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic starved_o
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] MAXV = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAXV)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved_o = (cnt_q == MAXV);

endmodule

// File: rtl/ej32_mem_arb.sv
// Arbitrates the single byte-wide SRAM port between the core and a host DMA burst.
// Optional statistics counters are built when EJ32_ARB_STAT_EN is defined.
module ej32_mem_arb
    import ej32_pkg::*;
#(
    parameter int ASZ        = ASZ_DEF,
    parameter int LSZ        = LSZ_DEF,
    parameter int STARVE_MAX = STARVE_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           core_req,
    input  logic           core_we,
    input  logic [ASZ-1:0] core_addr,
    input  logic [7:0]     core_wd,
    output logic [7:0]     core_rd,
    output logic           core_stall,
    input  logic           host_start,
    input  logic           host_we,
    input  logic [ASZ-1:0] host_base,
    input  logic [LSZ-1:0] host_len,
    input  logic [7:0]     host_wd,
    input  logic           host_wvalid,
    input  logic           host_rready,
    output logic [7:0]     host_rd,
    output logic           host_rvalid,
    output logic           host_wtake,
    output logic           host_busy,
    output logic           host_done,
    output logic [ASZ-1:0] mem_addr,
    output logic           mem_we,
    output logic [7:0]     mem_wd,
    input  logic [7:0]     mem_rd,
    output logic [15:0]    stat_core,
    output logic [15:0]    stat_host,
    output logic [15:0]    stat_stall
);

    arb_state_t     state_q, state_d;
    logic [ASZ-1:0] base_q, base_d;
    logic [LSZ-1:0] len_q, len_d;
    logic [LSZ-1:0] idx_q, idx_d;
    logic           we_q, we_d;
    logic [7:0]     rd_q, rd_d;
    logic           rvalid_q, rvalid_d;

    logic eligible;
    logic host_slot;
    logic starved;
    logic last_beat;
    logic accept;

    assign accept    = (state_q == IDLE) && host_start;
    assign eligible  = (state_q == BURST) &&
                       (we_q ? host_wvalid : host_rready);
    assign host_slot = eligible && (!core_req || starved);
    assign last_beat = ((idx_q + 1'b1) == len_q);

    // Only a core-won cycle with a waiting host counts toward starvation.
    ej32_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst),
        .inc_i     (eligible && !host_slot),
        .clr_i     (!(eligible && !host_slot)),
        .starved_o (starved)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (host_start) begin
                    state_d = (host_len == '0) ? DONE : BURST;
                end
            end
            BURST: begin
                if (host_slot && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        host_busy   = (state_q != IDLE);
        host_done   = (state_q == DONE);
        mem_addr    = core_addr;
        mem_we      = core_we && core_req;
        mem_wd      = core_wd;
        core_stall  = 1'b0;
        host_wtake  = 1'b0;
        if (host_slot) begin
            mem_addr   = base_q + ASZ'(idx_q);
            mem_we     = we_q;
            mem_wd     = host_wd;
            core_stall = core_req;
            host_wtake = we_q;
        end
    end

    assign core_rd     = mem_rd;
    assign host_rd     = rd_q;
    assign host_rvalid = rvalid_q;

    always_comb begin
        base_d   = base_q;
        len_d    = len_q;
        we_d     = we_q;
        idx_d    = idx_q;
        rvalid_d = host_slot && !we_q;
        rd_d     = rd_q;
        if (accept) begin
            base_d = host_base;
            len_d  = host_len;
            we_d   = host_we;
            idx_d  = '0;
        end else if (host_slot) begin
            idx_d = idx_q + 1'b1;
        end
        if (host_slot && !we_q) begin
            rd_d = mem_rd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q   <= '0;
            len_q    <= '0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            rd_q     <= '0;
            rvalid_q <= 1'b0;
        end else begin
            base_q   <= base_d;
            len_q    <= len_d;
            we_q     <= we_d;
            idx_q    <= idx_d;
            rd_q     <= rd_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef EJ32_ARB_STAT_EN
    arb_stat_t stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (core_req && !core_stall) begin
            stat_d.core = sat_inc(stat_q.core);
        end
        if (host_slot) begin
            stat_d.host = sat_inc(stat_q.host);
        end
        if (core_stall) begin
            stat_d.stall = sat_inc(stat_q.stall);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_core  = stat_q.core;
    assign stat_host  = stat_q.host;
    assign stat_stall = stat_q.stall;
`else
    assign stat_core  = '0;
    assign stat_host  = '0;
    assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Self-checking bench for ej32_mem_arb with a byte SRAM model.
// Expected beats are queued at stimulus time and popped as the DUT issues them.
module tb_ej32_mem_arb;

    logic        clk;
    logic        rst;
    logic        core_req, core_we;
    logic [16:0] core_addr;
    logic [7:0]  core_wd, core_rd;
    logic        core_stall;
    logic        host_start, host_we;
    logic [16:0] host_base;
    logic [8:0]  host_len;
    logic [7:0]  host_wd;
    logic        host_wvalid, host_rready;
    logic [7:0]  host_rd;
    logic        host_rvalid, host_wtake, host_busy, host_done;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wd, mem_rd;
    logic [15:0] stat_core, stat_host, stat_stall;

    logic [7:0]  mem [0:131071];
    logic [16:0] eq_a[$];
    logic [7:0]  eq_d[$];
    logic [7:0]  rq[$];

    int checks = 0;
    int errors = 0;

    ej32_mem_arb dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wd     (core_wd),
        .core_rd     (core_rd),
        .core_stall  (core_stall),
        .host_start  (host_start),
        .host_we     (host_we),
        .host_base   (host_base),
        .host_len    (host_len),
        .host_wd     (host_wd),
        .host_wvalid (host_wvalid),
        .host_rready (host_rready),
        .host_rd     (host_rd),
        .host_rvalid (host_rvalid),
        .host_wtake  (host_wtake),
        .host_busy   (host_busy),
        .host_done   (host_done),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wd      (mem_wd),
        .mem_rd      (mem_rd),
        .stat_core   (stat_core),
        .stat_host   (stat_host),
        .stat_stall  (stat_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: writes on the falling edge, asynchronous read.
    always @(negedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wd;
    end
    assign mem_rd = mem[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_write(input logic [16:0] a, input logic [7:0] d);
        core_req = 1'b1;
        core_we = 1'b1;
        core_addr = a;
        core_wd = d;
        tick();
        core_req = 1'b0;
        core_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        core_req = 0; core_we = 0; core_addr = '0; core_wd = '0;
        host_start = 0; host_we = 0; host_base = '0; host_len = '0;
        host_wd = '0; host_wvalid = 0; host_rready = 0;
        tick();
        tick();
        #3;
        checks++;
        if ({host_busy, host_done, host_rvalid, host_wtake,
             core_stall, mem_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b%b%b%b%b%b want 000000",
                     host_busy, host_done, host_rvalid, host_wtake,
                     core_stall, mem_we);
        end
        checks++;
        if (host_rd !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd got %h want 00", host_rd);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_core();
        logic [16:0] ta [3];
        logic [7:0]  td [3];
        logic [7:0]  e;
        int stalls;
        ta[0] = 17'h01000; td[0] = 8'h5A;
        ta[1] = 17'h00FFF; td[1] = 8'hC3;
        ta[2] = 17'h1FFFF; td[2] = 8'h01;
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            core_req = 1'b1; core_we = 1'b1;
            core_addr = ta[i]; core_wd = td[i];
            rq.push_back(td[i]);
            #3;
            if (core_stall) stalls++;
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== ta[i] || mem_wd !== td[i]) begin
                errors++;
                $display("FAIL core_wr got we %b a %h d %h want 1 %h %h",
                         mem_we, mem_addr, mem_wd, ta[i], td[i]);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            core_req = 1'b1; core_we = 1'b0; core_addr = ta[i];
            #3;
            if (core_stall) stalls++;
            e = rq.pop_front();
            checks++;
            if (core_rd !== e || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL core_rd got %h we %b want %h 0",
                         core_rd, mem_we, e);
            end
            tick();
        end
        core_req = 1'b0;
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL core_stall got %0d stalls want 0", stalls);
        end
    endtask

    task automatic host_write(input logic [16:0] base, input int len,
                              input logic [7:0] seed);
        int beats, last_t, dones;
        logic [16:0] a;
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            eq_a.push_back(base + 17'(i));
            eq_d.push_back(seed + 8'(i * 29));
        end
        host_start = 1'b1; host_we = 1'b1;
        host_base = base; host_len = 9'(len);
        host_wvalid = 1'b1;
        tick();
        host_start = 1'b0;
        beats = 0; last_t = -10; dones = 0;
        for (int t = 0; t < len + 6; t++) begin
            host_wd = (eq_d.size() != 0) ? eq_d[0] : 8'h00;
            #3;
            if (host_wtake) begin
                checks++;
                if (eq_a.size() == 0) begin
                    errors++;
                    $display("FAIL wr_extra beat at t=%0d addr %h", t, mem_addr);
                end else begin
                    a = eq_a.pop_front();
                    d = eq_d.pop_front();
                    if (mem_addr !== a || mem_wd !== d || mem_we !== 1'b1 ||
                        t != beats) begin
                        errors++;
                        $display("FAIL wr_beat t=%0d got %h %h %b want %h %h 1 t=%0d",
                                 t, mem_addr, mem_wd, mem_we, a, d, beats);
                    end
                end
                beats++;
                last_t = t;
            end
            if (host_done) begin
                dones++;
                checks++;
                if (t != last_t + 1) begin
                    errors++;
                    $display("FAIL wr_done_time got t=%0d want %0d", t, last_t + 1);
                end
            end
            tick();
        end
        host_wvalid = 1'b0;
        checks++;
        if (beats != len || dones != 1) begin
            errors++;
            $display("FAIL wr_count got beats %0d done %0d want %0d 1",
                     beats, dones, len);
        end
        eq_a.delete();
        eq_d.delete();
    endtask

    task automatic test_host_write();
        logic [7:0] e;
        host_write(17'h01000, 4, 8'h10);
        for (int i = 0; i < 4; i++) begin
            e = 8'h10 + 8'(i * 29);
            checks++;
            if (mem[17'h01000 + 17'(i)] !== e) begin
                errors++;
                $display("FAIL wr_mem[%0d] got %h want %h",
                         i, mem[17'h01000 + 17'(i)], e);
            end
        end
    endtask

    task automatic test_wrap();
        host_write(17'h1FFFE, 4, 8'h90);
        checks++;
        if (mem[17'h00001] !== 8'h90 + 8'(3 * 29)) begin
            errors++;
            $display("FAIL wrap_mem got %h want %h",
                     mem[17'h00001], 8'h90 + 8'(3 * 29));
        end
    endtask

    task automatic test_starve();
        int nst, dones;
        logic [7:0] e;
        core_write(17'h02000, 8'hA1);
        core_write(17'h02001, 8'hB2);
        core_write(17'h02002, 8'hC3);
        rq.push_back(8'hA1); rq.push_back(8'hB2); rq.push_back(8'hC3);
        core_req = 1'b1; core_we = 1'b0; core_addr = 17'h00040;
        host_start = 1'b1; host_we = 1'b0;
        host_base = 17'h02000; host_len = 9'd3; host_rready = 1'b1;
        tick();
        host_start = 1'b0;
        nst = 0; dones = 0;
        for (int t = 0; t < 60 && dones == 0; t++) begin
            #3;
            if (core_stall) begin
                checks++;
                if (t + 1 != 9 * (nst + 1) || mem_addr !== 17'h02000 + 17'(nst)) begin
                    errors++;
                    $display("FAIL starve_slot got cyc %0d a %h want cyc %0d a %h",
                             t + 1, mem_addr, 9 * (nst + 1), 17'h02000 + 17'(nst));
                end
                nst++;
            end
            if (host_rvalid) begin
                checks++;
                e = (rq.size() != 0) ? rq.pop_front() : 8'hXX;
                if (host_rd !== e) begin
                    errors++;
                    $display("FAIL starve_rd got %h want %h", host_rd, e);
                end
            end
            if (host_done) begin
                dones++;
                checks++;
                if (host_rvalid !== 1'b1 || nst != 3) begin
                    errors++;
                    $display("FAIL starve_done got rvalid %b stalls %0d want 1 3",
                             host_rvalid, nst);
                end
            end
            tick();
        end
        core_req = 1'b0; host_rready = 1'b0;
        checks++;
        if (dones != 1 || rq.size() != 0) begin
            errors++;
            $display("FAIL starve_end got done %0d left %0d want 1 0",
                     dones, rq.size());
        end
        rq.delete();
    endtask

    task automatic test_len0_ignore();
        int beats, dones;
        logic [7:0] e;
        host_start = 1'b1; host_we = 1'b1; host_len = 9'd0;
        host_base = 17'h00200;
        #3;
        checks++;
        if (mem_we !== 1'b0 || host_done !== 1'b0) begin
            errors++;
            $display("FAIL len0_c0 got we %b done %b want 0 0", mem_we, host_done);
        end
        tick();
        host_start = 1'b0;
        #3;
        checks++;
        if (host_done !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL len0_done got done %b we %b want 1 0", host_done, mem_we);
        end
        tick();
        #3;
        checks++;
        if (host_done !== 1'b0 || host_busy !== 1'b0) begin
            errors++;
            $display("FAIL len0_after got done %b busy %b want 0 0",
                     host_done, host_busy);
        end
        tick();
        rq.push_back(8'hA1); rq.push_back(8'hB2); rq.push_back(8'hC3);
        host_start = 1'b1; host_we = 1'b0;
        host_base = 17'h02000; host_len = 9'd3; host_rready = 1'b0;
        tick();
        host_base = 17'h00500; host_len = 9'd1;
        tick();
        host_start = 1'b0; host_rready = 1'b1;
        beats = 0; dones = 0;
        for (int t = 0; t < 10 && dones == 0; t++) begin
            #3;
            if (dut.host_slot === 1'b1 || mem_addr === 17'h00500) begin
                checks++;
                if (mem_addr !== 17'h02000 + 17'(beats)) begin
                    errors++;
                    $display("FAIL ign_addr got %h want %h",
                             mem_addr, 17'h02000 + 17'(beats));
                end
                beats++;
            end
            if (host_rvalid) begin
                checks++;
                e = (rq.size() != 0) ? rq.pop_front() : 8'hXX;
                if (host_rd !== e) begin
                    errors++;
                    $display("FAIL ign_rd got %h want %h", host_rd, e);
                end
            end
            if (host_done) dones++;
            tick();
        end
        host_rready = 1'b0;
        #3;
        checks++;
        if (beats != 3 || dones != 1 || host_busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_end got beats %0d done %0d busy %b want 3 1 0",
                     beats, dones, host_busy);
        end
        tick();
        rq.delete();
    endtask

    task automatic test_reset_mid();
        int takes, dones;
        host_start = 1'b1; host_we = 1'b1;
        host_base = 17'h03000; host_len = 9'd5;
        host_wvalid = 1'b1; host_wd = 8'h77;
        tick();
        host_start = 1'b0;
        takes = 0;
        for (int t = 0; t < 2; t++) begin
            #3;
            if (host_wtake) takes++;
            tick();
        end
        rst = 1'b0;
        #1;
        checks++;
        if (takes != 2 ||
            {host_busy, host_done, host_rvalid, host_wtake,
             core_stall, mem_we} !== 6'b0 || host_rd !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid got takes %0d flags %b%b%b%b%b%b rd %h want 2 000000 00",
                     takes, host_busy, host_done, host_rvalid, host_wtake,
                     core_stall, mem_we, host_rd);
        end
        tick();
        tick();
        rst = 1'b1;
        dones = 0;
        for (int t = 0; t < 3; t++) begin
            #3;
            if (host_done || host_busy || host_wtake) dones++;
            tick();
        end
        host_wvalid = 1'b0;
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL rst_no_done got %0d active cycles want 0", dones);
        end
        host_write(17'h03100, 2, 8'h40);
    endtask

    initial begin
        test_reset();
        test_core();
        test_host_write();
        test_wrap();
        test_starve();
        test_len0_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
